// File: rtl/fetch_decode_reg_pkg.sv
// rtl/fetch_decode_reg_pkg.sv - shared pipeline types and constants for the IF/ID register
package fetch_decode_reg_pkg;

  localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } pipe_d_t;

endpackage

// File: rtl/fetch_decode_reg_skid_entry.sv
// rtl/fetch_decode_reg_skid_entry.sv - one-slot skid buffer with load/clear
module skid_entry
  import fetch_decode_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  pipe_d_t entry_q;
  pipe_d_t entry_d;

  // Clear wins over load so a squash can never leave a stale beat parked.
  always_comb begin
    entry_d = entry_q;
    if (clr) begin
      entry_d.valid = 1'b0;
    end else if (load) begin
      entry_d = '{valid: 1'b1, pc: pc_i, instr: instr_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '{valid: 1'b0, pc: 32'h0, instr: PIPE_NOP_INSN};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o = entry_q.valid;
  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;

endmodule

// File: rtl/fetch_decode_reg.sv
// rtl/fetch_decode_reg.sv - IF/ID pipeline register with stall skid and post-redirect drain
module fetch_decode_reg
  import fetch_decode_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FLUSH_DROP = 1,
  parameter logic [31:0] NOP_INSN   = PIPE_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_i_regD_stall,
  input  logic        ctrl_i_regD_bubble,
  input  logic        fetch_i_valid,
  input  logic [31:0] fetch_i_pc,
  input  logic [31:0] fetch_i_instr,
  output logic        fetch_o_ready,
  output logic        decode_o_valid,
  output logic [31:0] decode_o_pc,
  output logic [31:0] decode_o_instr
);

  localparam int CNT_W = (FLUSH_DROP > 0) ? $clog2(FLUSH_DROP + 1) : 1;

  pipe_d_t          dec_q;
  pipe_d_t          dec_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] drop_cnt_d;

  logic        skid_v;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_load;
  logic        skid_clr;
  logic        accept;

  skid_entry u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clr     (skid_clr),
    .pc_i    (fetch_i_pc),
    .instr_i (fetch_i_instr),
    .valid_o (skid_v),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign fetch_o_ready = !skid_v;
  assign accept        = fetch_i_valid && fetch_o_ready;

  // Priority: bubble > drain > stall > advance; the skid is never loaded while draining.
  always_comb begin
    dec_d      = dec_q;
    drop_cnt_d = drop_cnt_q;
    skid_load  = 1'b0;
    skid_clr   = 1'b0;
    if (ctrl_i_regD_bubble) begin
      dec_d.valid = 1'b0;
      skid_clr    = 1'b1;
      drop_cnt_d  = CNT_W'(FLUSH_DROP);
    end else if (drop_cnt_q != '0) begin
      if (accept) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (!ctrl_i_regD_stall) begin
        dec_d.valid = 1'b0;
      end
    end else if (ctrl_i_regD_stall) begin
      skid_load = accept;
    end else if (skid_v) begin
      dec_d    = '{valid: 1'b1, pc: skid_pc, instr: skid_instr};
      skid_clr = 1'b1;
    end else if (accept) begin
      dec_d = '{valid: 1'b1, pc: fetch_i_pc, instr: fetch_i_instr};
    end else begin
      dec_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q      <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSN};
      drop_cnt_q <= '0;
    end else begin
      dec_q      <= dec_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign decode_o_valid = dec_q.valid;
  assign decode_o_pc    = dec_q.pc;
  assign decode_o_instr = dec_q.valid ? dec_q.instr : NOP_INSN;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb/tb_fetch_decode_reg.sv - vector table plus randomized reference-model bench for fetch_decode_reg
module tb_fetch_decode_reg;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam int          FLUSH_DROP = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] IMASK      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        bubble = 1'b0;
  logic        fvalid = 1'b0;
  logic [31:0] fpc = 32'h0;
  logic [31:0] finstr = 32'h0;
  logic        fready;
  logic        dvalid;
  logic [31:0] dpc;
  logic [31:0] dinstr;

  int checks = 0;
  int errors = 0;

  fetch_decode_reg #(
    .RESET_PC   (RESET_PC),
    .FLUSH_DROP (FLUSH_DROP),
    .NOP_INSN   (NOP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_i_regD_stall  (stall),
    .ctrl_i_regD_bubble (bubble),
    .fetch_i_valid      (fvalid),
    .fetch_i_pc         (fpc),
    .fetch_i_instr      (finstr),
    .fetch_o_ready      (fready),
    .decode_o_valid     (dvalid),
    .decode_o_pc        (dpc),
    .decode_o_instr     (dinstr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          s;
    bit          b;
    bit          v;
    logic [31:0] pc;
    bit          exp_rdy;
    bit          exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  // Reference model: decode slot, a queue of parked beats, and a count of beats still to discard.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  beat_t       m_pend[$];
  int          m_drop;
  bit          m_rdy;
  logic        got_rdy;

  task automatic model_update(input bit r, input bit s, input bit b, input bit v,
                              input logic [31:0] pc, input logic [31:0] instr);
    bit acc;
    beat_t bt;
    m_rdy = (m_pend.size() == 0);
    acc   = v && m_rdy;
    if (r) begin
      m_valid = 0; m_pc = RESET_PC; m_pend.delete(); m_drop = 0;
    end else if (b) begin
      m_valid = 0; m_pend.delete(); m_drop = FLUSH_DROP;
    end else if (m_drop > 0) begin
      if (acc) m_drop = m_drop - 1;
      if (!s) m_valid = 0;
    end else if (s) begin
      if (acc) begin
        bt.pc = pc; bt.instr = instr;
        m_pend.push_back(bt);
      end
    end else if (m_pend.size() > 0) begin
      bt = m_pend.pop_front();
      m_valid = 1; m_pc = bt.pc; m_instr = bt.instr;
    end else if (acc) begin
      m_valid = 1; m_pc = pc; m_instr = instr;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit b, input bit v,
                      input logic [31:0] pc, input logic [31:0] instr);
    rst = r; stall = s; bubble = b; fvalid = v; fpc = pc; finstr = instr;
    #1;
    got_rdy = fready;
    model_update(r, s, b, v, pc, instr);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[30];

  initial begin
    vecs[0]  = '{0,0,0,1,32'h100, 1,1,32'h100};
    vecs[1]  = '{0,0,0,1,32'h104, 1,1,32'h104};
    vecs[2]  = '{0,0,0,1,32'h108, 1,1,32'h108};
    vecs[3]  = '{0,0,0,0,32'h0,   1,0,32'h108};
    vecs[4]  = '{0,1,0,1,32'h200, 1,0,32'h108};
    vecs[5]  = '{0,1,0,1,32'h204, 0,0,32'h108};
    vecs[6]  = '{0,1,0,1,32'h204, 0,0,32'h108};
    vecs[7]  = '{0,0,0,1,32'h204, 0,1,32'h200};
    vecs[8]  = '{0,0,0,1,32'h204, 1,1,32'h204};
    vecs[9]  = '{0,0,0,0,32'h0,   1,0,32'h204};
    vecs[10] = '{0,0,1,1,32'h300, 1,0,32'h204};
    vecs[11] = '{0,0,0,1,32'h304, 1,0,32'h204};
    vecs[12] = '{0,0,0,1,32'h308, 1,0,32'h204};
    vecs[13] = '{0,0,0,1,32'h30C, 1,1,32'h30C};
    vecs[14] = '{0,0,0,0,32'h0,   1,0,32'h30C};
    vecs[15] = '{0,0,0,1,32'h500, 1,1,32'h500};
    vecs[16] = '{0,1,0,1,32'h504, 1,1,32'h500};
    vecs[17] = '{0,1,1,1,32'h508, 0,0,32'h500};
    vecs[18] = '{0,0,0,0,32'h0,   1,0,32'h500};
    vecs[19] = '{0,0,0,1,32'h600, 1,0,32'h500};
    vecs[20] = '{1,0,0,1,32'h604, 1,0,RESET_PC};
    vecs[21] = '{0,0,0,1,32'h400, 1,1,32'h400};
    vecs[22] = '{0,0,0,0,32'h0,   1,0,32'h400};
    vecs[23] = '{0,0,0,1,32'h700, 1,1,32'h700};
    vecs[24] = '{0,0,1,0,32'h0,   1,0,32'h700};
    vecs[25] = '{0,0,0,1,32'h704, 1,0,32'h700};
    vecs[26] = '{0,0,1,1,32'h708, 1,0,32'h700};
    vecs[27] = '{0,0,0,1,32'h70C, 1,0,32'h700};
    vecs[28] = '{0,0,0,1,32'h710, 1,0,32'h700};
    vecs[29] = '{0,0,0,1,32'h714, 1,1,32'h714};

    @(negedge clk);
    step(1, 0, 0, 0, 32'h0, 32'h0);
    chk("reset_valid", -1, {31'h0, dvalid}, 32'h0);
    chk("reset_pc",    -1, dpc, RESET_PC);
    chk("reset_instr", -1, dinstr, NOP);
    chk("reset_ready", -1, {31'h0, fready}, 32'h1);

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].b, vecs[i].v, vecs[i].pc, vecs[i].pc ^ IMASK);
      chk("ready", i, {31'h0, got_rdy}, {31'h0, vecs[i].exp_rdy});
      chk("valid", i, {31'h0, dvalid}, {31'h0, vecs[i].exp_v});
      chk("pc",    i, dpc, vecs[i].exp_pc);
      chk("instr", i, dinstr, vecs[i].exp_v ? (vecs[i].exp_pc ^ IMASK) : NOP);
    end

    for (int i = 0; i < 400; i++) begin
      bit r, s, b, v;
      logic [31:0] pc, ins;
      r   = ($urandom_range(0, 99) < 2);
      s   = ($urandom_range(0, 99) < 30);
      b   = ($urandom_range(0, 99) < 6);
      v   = ($urandom_range(0, 99) < 70);
      pc  = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h1000;
      ins = $urandom;
      step(r, s, b, v, pc, ins);
      chk("rnd_ready", i, {31'h0, got_rdy}, {31'h0, m_rdy});
      chk("rnd_valid", i, {31'h0, dvalid}, {31'h0, m_valid});
      chk("rnd_pc",    i, dpc, m_pc);
      chk("rnd_instr", i, dinstr, m_valid ? m_instr : NOP);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
